operand2_decoder: RTL and testbench

//  Front end for the barrel shifter: takes a data-processing instruction, fetches
//  Rm (and Rs for register-specified shifts) through one register-file read port,
//  and issues a registered {Shift_OP, Shift_Data, Shift_Num} command to the shifter.

---
 rtl/operand2_decoder_if.sv | 30 +++
 rtl/operand2_decoder.sv | 106 ++++++++++
 tb/tb_operand2_decoder.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/operand2_decoder_if.sv
// Handshake and bus bundle between decode, register file read port and barrel shifter.
// The decoder uses the slave modport; the decode/regfile/shifter environment uses master.
interface operand2_decoder_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4
) ();
    logic                  In_Valid;
    logic                  In_Ready;
    logic [31:0]           Inst;
    logic                  Reg_Req;
    logic [REG_ADDR_W-1:0] Reg_Addr;
    logic                  Reg_Ack;
    logic [DATA_W-1:0]     Reg_Data;
    logic [DATA_W-1:0]     PC;
    logic                  Out_Valid;
    logic                  Out_Ready;
    logic [2:0]            Shift_OP;
    logic [DATA_W-1:0]     Shift_Data;
    logic [7:0]            Shift_Num;

    modport slave (
        input  In_Valid, Inst, Reg_Ack, Reg_Data, PC, Out_Ready,
        output In_Ready, Reg_Req, Reg_Addr, Out_Valid, Shift_OP, Shift_Data, Shift_Num
    );

    modport master (
        output In_Valid, Inst, Reg_Ack, Reg_Data, PC, Out_Ready,
        input  In_Ready, Reg_Req, Reg_Addr, Out_Valid, Shift_OP, Shift_Data, Shift_Num
    );
endinterface

// File: rtl/operand2_decoder.sv
// Operand-2 front end: decodes a data-processing word, reads Rm/Rs, issues a shift command.
// Latency accept->Out_Valid: imm 1 cycle, imm-shift 1+ack wait, reg-shift 2+ack waits.
// Backpressure: In_Ready only in IDLE; command held until Out_Ready. OPERAND2_PC_READ_EN: R15 = PC+8/+12.
module operand2_decoder #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    operand2_decoder_if.slave  io
);
    typedef enum logic [1:0] {IDLE, READ_RM, READ_RS, ISSUE} state_t;

    state_t                state;
    logic [REG_ADDR_W-1:0] rs_idx;
    logic                  reg_shift;
    logic [DATA_W-1:0]     pc_val;

`ifdef OPERAND2_PC_READ_EN
    localparam bit PC_READ = 1'b1;
    // Architectural R15 reads as PC+8, or PC+12 when a register-specified shift adds a cycle.
    assign pc_val = io.PC + (reg_shift ? DATA_W'(12) : DATA_W'(8));
`else
    localparam bit PC_READ = 1'b0;
    assign pc_val = '0;
    wire unused_pc = ^io.PC;
`endif

    wire unused_inst = ^{io.Inst[31:26], io.Inst[24:12]};

    function automatic logic is_pc(input logic [REG_ADDR_W-1:0] idx);
        return PC_READ && (idx == {REG_ADDR_W{1'b1}});
    endfunction

    wire cur_is_pc = is_pc(io.Reg_Addr);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            io.In_Ready   <= 1'b1;
            io.Reg_Req    <= 1'b0;
            io.Reg_Addr   <= '0;
            io.Out_Valid  <= 1'b0;
            io.Shift_OP   <= 3'b000;
            io.Shift_Data <= '0;
            io.Shift_Num  <= 8'h00;
            rs_idx        <= '0;
            reg_shift     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (io.In_Valid) begin
                        io.In_Ready <= 1'b0;
                        rs_idx      <= io.Inst[11:8];
                        reg_shift   <= io.Inst[4];
                        if (io.Inst[25]) begin
                            // Rotated immediate: rotate amount is twice the 4-bit field, no RRX.
                            io.Shift_OP   <= 3'b111;
                            io.Shift_Data <= DATA_W'(io.Inst[7:0]);
                            io.Shift_Num  <= {3'b000, io.Inst[11:8], 1'b0};
                            io.Out_Valid  <= 1'b1;
                            state         <= ISSUE;
                        end else begin
                            io.Shift_OP  <= {io.Inst[6:5], io.Inst[4]};
                            io.Shift_Num <= io.Inst[4] ? 8'h00 : {3'b000, io.Inst[11:7]};
                            io.Reg_Addr  <= io.Inst[3:0];
                            io.Reg_Req   <= !is_pc(io.Inst[3:0]);
                            state        <= READ_RM;
                        end
                    end
                end
                READ_RM: begin
                    if (cur_is_pc || io.Reg_Ack) begin
                        io.Shift_Data <= cur_is_pc ? pc_val : io.Reg_Data;
                        if (reg_shift) begin
                            io.Reg_Addr <= rs_idx;
                            io.Reg_Req  <= !is_pc(rs_idx);
                            state       <= READ_RS;
                        end else begin
                            io.Reg_Req   <= 1'b0;
                            io.Out_Valid <= 1'b1;
                            state        <= ISSUE;
                        end
                    end
                end
                READ_RS: begin
                    if (cur_is_pc || io.Reg_Ack) begin
                        // Full 0..255 amount is forwarded; the shifter handles >=32.
                        io.Shift_Num <= cur_is_pc ? pc_val[7:0] : io.Reg_Data[7:0];
                        io.Reg_Req   <= 1'b0;
                        io.Out_Valid <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (io.Out_Ready) begin
                        io.Out_Valid <= 1'b0;
                        io.In_Ready  <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_operand2_decoder.sv
// Randomised bench for operand2_decoder with a behavioural command model and a register-file responder.
module tb_operand2_decoder;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    operand2_decoder_if #(.DATA_W(32), .REG_ADDR_W(4)) io ();
    operand2_decoder #(.DATA_W(32), .REG_ADDR_W(4)) dut (.clock(clock), .reset(reset), .io(io));

    int          checks = 0;
    int          errors = 0;
    logic [31:0] regfile [16];
    logic [3:0]  addr_log [$];
    logic [3:0]  exp_addrs [$];
    int          ack_max = 0;
    bit          resp_hold = 1'b0;
    bit          exp_pending = 1'b0;
    logic [2:0]  exp_op;
    logic [31:0] exp_data;
    logic [7:0]  exp_num;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] reg_value(input logic [3:0] idx, input logic [31:0] pc, input int off);
`ifdef OPERAND2_PC_READ_EN
        if (idx == 4'd15) return pc + 32'(off);
`endif
        exp_addrs.push_back(idx);
        return regfile[idx];
    endfunction

    // What the shifter must receive, from the instruction fields and register contents.
    function automatic void model(input logic [31:0] inst, input logic [31:0] pc,
                                  output logic [2:0] op, output logic [31:0] data,
                                  output logic [7:0] num, output int nstates);
        int off;
        logic [31:0] rsv;
        exp_addrs.delete();
        off = inst[4] ? 12 : 8;
        if (inst[25]) begin
            op      = 3'd7;
            data    = inst & 32'hFF;
            num     = 8'(((inst >> 8) & 32'hF) * 2);
            nstates = 0;
        end else begin
            op      = 3'(((inst >> 5) & 32'h3) * 2 + {31'b0, inst[4]});
            nstates = inst[4] ? 2 : 1;
            data    = reg_value(inst[3:0], pc, off);
            if (inst[4]) begin
                rsv = reg_value(inst[11:8], pc, off);
                num = 8'(rsv % 256);
            end else begin
                num = 8'((inst >> 7) & 32'h1F);
            end
        end
    endfunction

    // Register file port: acks after a random wait, logging each served address.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        io.Reg_Ack  = 1'b0;
        io.Reg_Data = '0;
        forever begin
            @(posedge clock);
            #1;
            io.Reg_Ack = 1'b0;
            if (io.Reg_Req && !resp_hold && reset) begin
                if (wait_cnt == 0) begin
                    io.Reg_Ack  = 1'b1;
                    io.Reg_Data = regfile[io.Reg_Addr];
                    addr_log.push_back(io.Reg_Addr);
                    wait_cnt = $urandom_range(0, ack_max);
                end else begin
                    wait_cnt--;
                    io.Reg_Data = $urandom;
                end
            end else begin
                io.Reg_Data = $urandom;
            end
        end
    end

    always @(negedge clock) begin
        if (reset && io.Out_Valid) begin
            if (!exp_pending) begin
                chk("spurious_out_valid", {31'b0, io.Out_Valid}, 32'd0);
            end else begin
                chk("shift_op", {29'b0, io.Shift_OP}, {29'b0, exp_op});
                chk("shift_data", io.Shift_Data, exp_data);
                chk("shift_num", {24'b0, io.Shift_Num}, {24'b0, exp_num});
                chk("in_ready_busy", {31'b0, io.In_Ready}, 32'd0);
            end
        end
    end

    task automatic run_inst(input logic [31:0] inst, input int stall, input bit check_lat,
                            input bit pin, input logic [2:0] pop, input logic [31:0] pdata,
                            input logic [7:0] pnum, input int pnreads);
        int nstates;
        int cnt;
        model(inst, io.PC, exp_op, exp_data, exp_num, nstates);
        addr_log.delete();
        cnt = 0;
        while (!io.In_Ready && cnt < 50) begin
            @(posedge clock);
            #1;
            cnt++;
        end
        chk("in_ready_idle", {31'b0, io.In_Ready}, 32'd1);
        io.In_Valid  = 1'b1;
        io.Inst      = inst;
        io.Out_Ready = 1'b0;
        @(posedge clock);
        #1;
        io.In_Valid = 1'b0;
        io.Inst     = $urandom;
        exp_pending = 1'b1;
        cnt = 0;
        do begin
            @(negedge clock);
            cnt++;
        end while (!io.Out_Valid && cnt < 100);
        chk("out_valid_seen", {31'b0, io.Out_Valid}, 32'd1);
        if (check_lat) chk("latency", cnt, 32'(1 + nstates));
        if (pin) begin
            chk("pin_op", {29'b0, io.Shift_OP}, {29'b0, pop});
            chk("pin_data", io.Shift_Data, pdata);
            chk("pin_num", {24'b0, io.Shift_Num}, {24'b0, pnum});
        end
        // Stall with a competing instruction offered; it must not be taken.
        for (int i = 0; i < stall; i++) begin
            @(posedge clock);
            #1;
            io.In_Valid = 1'b1;
            io.Inst     = $urandom;
        end
        @(posedge clock);
        #1;
        io.In_Valid  = 1'b0;
        io.Out_Ready = 1'b1;
        @(posedge clock);
        #1;
        io.Out_Ready = 1'b0;
        exp_pending  = 1'b0;
        chk("in_ready_after", {31'b0, io.In_Ready}, 32'd1);
        chk("out_valid_after", {31'b0, io.Out_Valid}, 32'd0);
        chk("nreads", 32'(addr_log.size()), 32'(exp_addrs.size()));
        if (pin) chk("pin_nreads", 32'(addr_log.size()), 32'(pnreads));
        for (int i = 0; i < addr_log.size() && i < exp_addrs.size(); i++)
            chk("read_addr", {28'b0, addr_log[i]}, {28'b0, exp_addrs[i]});
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_in_ready"}, {31'b0, io.In_Ready}, 32'd1);
        chk({tag, "_req"}, {31'b0, io.Reg_Req}, 32'd0);
        chk({tag, "_addr"}, {28'b0, io.Reg_Addr}, 32'd0);
        chk({tag, "_out_valid"}, {31'b0, io.Out_Valid}, 32'd0);
        chk({tag, "_op"}, {29'b0, io.Shift_OP}, 32'd0);
        chk({tag, "_data"}, io.Shift_Data, 32'd0);
        chk({tag, "_num"}, {24'b0, io.Shift_Num}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        io.In_Valid  = 1'b0;
        io.Inst      = '0;
        io.Out_Ready = 1'b0;
        io.PC        = 32'h100;
        for (int i = 0; i < 16; i++) regfile[i] = $urandom;
        repeat (3) @(posedge clock);
        #1;
        check_idle_outputs("reset");
        reset = 1'b1;

        ack_max = 0;
        run_inst(32'h02A004FF, 0, 1'b1, 1'b1, 3'b111, 32'hFF, 8'd8, 0);
        regfile[3] = 32'h12345678;
        run_inst(32'h01A00023, 0, 1'b1, 1'b1, 3'b010, 32'h12345678, 8'd0, 1);
        regfile[1] = 32'h12345678;
        regfile[2] = 32'h00000064;
        run_inst(32'h01A00271, 0, 1'b1, 1'b1, 3'b111, 32'h12345678, 8'd100, 2);
        run_inst(32'h01A00271, 3, 1'b1, 1'b1, 3'b111, 32'h12345678, 8'd100, 2);

        // Reset while Rs read is outstanding.
        addr_log.delete();
        io.In_Valid = 1'b1;
        io.Inst     = 32'h01A00271;
        @(posedge clock);
        #1;
        io.In_Valid = 1'b0;
        cnt = 0;
        do begin
            @(negedge clock);
            cnt++;
        end while (addr_log.size() < 1 && cnt < 20);
        resp_hold = 1'b1;
        chk("rm_read_before_reset", 32'(addr_log.size()), 32'd1);
        repeat (2) @(negedge clock);
        chk("rs_req_pending", {31'b0, io.Reg_Req}, 32'd1);
        reset = 1'b0;
        #1;
        check_idle_outputs("midreset");
        @(negedge clock);
        reset     = 1'b1;
        resp_hold = 1'b0;
        run_inst(32'h01A00271, 1, 1'b1, 1'b1, 3'b111, 32'h12345678, 8'd100, 2);

`ifdef OPERAND2_PC_READ_EN
        io.PC = 32'h100;
        run_inst(32'h01A0000F, 0, 1'b1, 1'b1, 3'b000, 32'h108, 8'd0, 0);
        regfile[3] = 32'h5;
        run_inst(32'h01A0031F, 0, 1'b1, 1'b1, 3'b001, 32'h10C, 8'd5, 1);
`endif

        for (int n = 0; n < 200; n++) begin
            for (int i = 0; i < 16; i++) regfile[i] = $urandom;
            io.PC   = $urandom & 32'hFFFF_FFFC;
            ack_max = (n < 40) ? 0 : 3;
            run_inst($urandom, $urandom_range(0, 2), (ack_max == 0), 1'b0, 3'b0, 32'h0, 8'h0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
